// File: rtl/mem_filler_pkg.sv
// Shared definitions for the dcache line filler: state encoding, beat geometry, line alignment.
package mem_filler_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WB    = 3'd1;
    localparam logic [2:0] ST_WBACK = 3'd2;
    localparam logic [2:0] ST_PROBE = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_RD    = 3'd5;
    localparam logic [2:0] ST_FILL  = 3'd6;

    typedef struct packed {
        logic [31:0] addr;
        logic        is_pf;
    } line_req_t;

    function automatic int beats_f(input int log2line, input int log2dw);
        return 1 << (log2line - log2dw);
    endfunction

    // $clog2(BEATS)+1, so the counter can hold BEATS itself
    function automatic int cnt_w_f(input int log2line, input int log2dw);
        return log2line - log2dw + 1;
    endfunction

    function automatic logic [31:0] line_align(input logic [31:0] a, input int log2line);
        return a & ~((32'd1 << (log2line - 3)) - 32'd1);
    endfunction

endpackage

// File: rtl/mem_dcache_filler_if.sv
// DRAM read/write command bus between the line filler (master) and the memory controller (slave).
interface mem_dcache_filler_if #(parameter int DW = 128);
    logic [31:0]   dram_rd_addr;
    logic          dram_rd_en;
    logic          dram_rd_wait;
    logic [DW-1:0] dram_rd_data;
    logic          dram_rd_valid;
    logic [31:0]   dram_wr_addr;
    logic [DW-1:0] dram_wr_data;
    logic          dram_wr_en;
    logic          dram_wr_ack;

    modport master (
        output dram_rd_addr, dram_rd_en,
        input  dram_rd_wait, dram_rd_data, dram_rd_valid,
        output dram_wr_addr, dram_wr_data, dram_wr_en,
        input  dram_wr_ack
    );

    modport slave (
        input  dram_rd_addr, dram_rd_en,
        output dram_rd_wait, dram_rd_data, dram_rd_valid,
        input  dram_wr_addr, dram_wr_data, dram_wr_en,
        output dram_wr_ack
    );
endinterface

// File: rtl/mem_line_assembler.sv
// Collects in-order DRAM beats into one cache line; beat k lands at line[k*DW +: DW].
module mem_line_assembler #(
    parameter int BEATS = 4,
    parameter int DW    = 128,
    parameter int CW    = 3
) (
    input  logic                mem_clk,
    input  logic                resetn,
    input  logic                clr,
    input  logic                beat_valid,
    input  logic [DW-1:0]       beat_data,
    output logic [BEATS*DW-1:0] line,
    output logic                done
);
    logic [CW-1:0] beat_idx;
    logic          take;

    assign done = (beat_idx == CW'(BEATS));
    assign take = beat_valid && !done;

    always_ff @(posedge mem_clk or negedge resetn) begin
        if (!resetn)   beat_idx <= '0;
        else if (clr)  beat_idx <= '0;
        else if (take) beat_idx <= beat_idx + 1'b1;
    end

    for (genvar k = 0; k < BEATS; k++) begin : g_slot
        logic [DW-1:0] q;
        always_ff @(posedge mem_clk or negedge resetn) begin
            if (!resetn)                             q <= '0;
            else if (clr)                            q <= '0;
            else if (take && beat_idx == CW'(k))     q <= beat_data;
        end
        assign line[k*DW +: DW] = q;
    end
endmodule

// File: rtl/mem_dcache_filler.sv
// Dcache miss filler and write-back forwarder. Optional next-line prefetch: MEM_FILLER_PREFETCH_EN.
module mem_dcache_filler import mem_filler_pkg::*; #(
    parameter int LOG2CACHELINESIZE = 7,
    parameter int LOG2DRAMWIDTHBITS = 7,
    parameter int FILL_GAP          = 2
) (
    input  logic                                mem_clk,
    input  logic                                resetn,
    input  logic                                req_valid,
    input  logic [31:0]                         req_addr,
    output logic                                req_ready,
    output logic [31:0]                         mem_filladdr,
    output logic [(1<<LOG2CACHELINESIZE)-1:0]   mem_filldata,
    output logic                                mem_fillwe,
    output logic                                mem_fillrddirty,
    input  logic [31:0]                         mem_wbaddr,
    input  logic [(1<<LOG2DRAMWIDTHBITS)-1:0]   mem_wbdata,
    input  logic                                mem_wbwe,
    output logic                                mem_wback,
    mem_dcache_filler_if.master                 dram
);
    localparam int CL         = 1 << LOG2CACHELINESIZE;
    localparam int DW         = 1 << LOG2DRAMWIDTHBITS;
    localparam int BEATS      = beats_f(LOG2CACHELINESIZE, LOG2DRAMWIDTHBITS);
    localparam int CW         = cnt_w_f(LOG2CACHELINESIZE, LOG2DRAMWIDTHBITS);
    localparam int BEAT_BYTES = DW / 8;
    localparam int GW         = $clog2(FILL_GAP) + 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(FILL_GAP - 2);

    logic [2:0]    state;
    logic          run, wb_hold;
    line_req_t     cur;
    logic [31:0]   wb_addr_q;
    logic [DW-1:0] wb_data_q;
    logic [CW-1:0] issued;
    logic [GW-1:0] gap_cnt;
    logic          rd_phase, beat_valid, done;
    logic          idle_live, wb_take, req_take, pf_take, pf_go;
    logic [31:0]   pf_addr;

    assign rd_phase  = (state == ST_WAIT) || (state == ST_RD);
    assign idle_live = run && (state == ST_IDLE);
    assign req_ready = idle_live && !mem_wbwe;
    // first IDLE cycle after an ack skips the stale write-back beat
    assign wb_take   = idle_live && mem_wbwe && !wb_hold;
    assign req_take  = req_ready && req_valid;
    assign pf_take   = req_ready && !req_valid && pf_go;

`ifdef MEM_FILLER_PREFETCH_EN
    logic pf_armed;
    always_ff @(posedge mem_clk or negedge resetn) begin
        if (!resetn) begin
            pf_armed <= 1'b0;
            pf_addr  <= '0;
        end else if (state == ST_FILL && !cur.is_pf) begin
            pf_armed <= 1'b1;
            pf_addr  <= cur.addr + 32'(CL / 8);
        end else if (pf_take) begin
            pf_armed <= 1'b0;
        end
    end
    assign pf_go = pf_armed;
`else
    assign pf_go   = 1'b0;
    assign pf_addr = '0;
`endif

    assign dram.dram_rd_en   = rd_phase && (issued < CW'(BEATS));
    assign dram.dram_rd_addr = cur.addr + 32'(issued) * 32'(BEAT_BYTES);
    assign dram.dram_wr_en   = (state == ST_WB);
    assign dram.dram_wr_addr = wb_addr_q;
    assign dram.dram_wr_data = wb_data_q;
    assign beat_valid        = rd_phase && dram.dram_rd_valid;

    assign mem_filladdr    = cur.addr;
    assign mem_fillrddirty = (state == ST_PROBE);
    assign mem_fillwe      = (state == ST_FILL);
    assign mem_wback       = (state == ST_WBACK);

    mem_line_assembler #(.BEATS(BEATS), .DW(DW), .CW(CW)) u_asm (
        .mem_clk    (mem_clk),
        .resetn     (resetn),
        .clr        (state == ST_PROBE),
        .beat_valid (beat_valid),
        .beat_data  (dram.dram_rd_data),
        .line       (mem_filldata),
        .done       (done)
    );

    always_ff @(posedge mem_clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            run       <= 1'b0;
            wb_hold   <= 1'b0;
            cur       <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            issued    <= '0;
            gap_cnt   <= '0;
        end else begin
            run     <= 1'b1;
            wb_hold <= (state == ST_WBACK);
            if (dram.dram_rd_en && !dram.dram_rd_wait) issued <= issued + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (wb_take) begin
                        wb_addr_q <= mem_wbaddr;
                        wb_data_q <= mem_wbdata;
                        state     <= ST_WB;
                    end else if (req_take) begin
                        cur   <= '{addr: line_align(req_addr, LOG2CACHELINESIZE), is_pf: 1'b0};
                        state <= ST_PROBE;
                    end else if (pf_take) begin
                        cur   <= '{addr: pf_addr, is_pf: 1'b1};
                        state <= ST_PROBE;
                    end
                end
                ST_WB:    if (dram.dram_wr_ack) state <= ST_WBACK;
                ST_WBACK: state <= ST_IDLE;
                ST_PROBE: begin
                    issued  <= '0;
                    gap_cnt <= '0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_cnt == GAP_LAST) state <= ST_RD;
                end
                ST_RD:    if (done) state <= ST_FILL;
                ST_FILL:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end
endmodule
